// File: rtl/motor_pkg.sv
// Shared types and helpers for the multi-channel H-bridge motor driver.
// Optional build macro: MOTOR_RAMP_EN (slew-limited duty changes, used by pwm_channel).
package motor_pkg;

  // Per-channel bridge sequencing state
  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_DRAIN,
    CH_DEAD
  } ch_state_e;

  // Full-scale duty of the default 8-bit PWM counter (continuous-on level)
  localparam int unsigned PWM_MAX = 255;

  // Move cur toward tgt by at most lim, landing exactly on tgt without overshoot
  function automatic int unsigned sat_step(input int unsigned cur,
                                           input int unsigned tgt,
                                           input int unsigned lim);
    if (tgt > cur) begin
      return ((tgt - cur) > lim) ? (cur + lim) : tgt;
    end else begin
      return ((cur - tgt) > lim) ? (cur - lim) : tgt;
    end
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One H-bridge channel: sequencing FSM, applied-duty register and PWM comparator.
// Optional build macro: MOTOR_RAMP_EN -- duty moves at most RAMP_STEP per period;
// without it the applied duty jumps to the target at each period start.
module pwm_channel
  import motor_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_wrap,
  input  logic [PWM_BITS-1:0] i_cnt,
  input  logic                i_obstacle,
  input  logic                i_dir,
  input  logic [PWM_BITS-1:0] i_duty_target,
  output logic                o_en_out,
  output logic                o_in_a,
  output logic                o_in_b,
  output logic [PWM_BITS-1:0] o_duty_now
);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

`ifdef MOTOR_RAMP_EN
  localparam int unsigned STEP_LIM = int'(RAMP_STEP);
`else
  // A step larger than the whole duty range reaches any target in one period
  localparam int unsigned STEP_LIM = int'(RAMP_STEP) + (32'd1 << PWM_BITS);
`endif

  ch_state_e           r_state;
  logic                r_dir;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_en_out;
  logic                r_in_a;
  logic                r_in_b;

  logic [PWM_BITS-1:0] w_target;
  logic [PWM_BITS-1:0] w_goal;
  logic [PWM_BITS-1:0] w_next;
  logic                w_active;
  logic                w_pwm;

  // Forward motion is suppressed while an obstacle is present; reverse never is
  assign w_target = (i_obstacle && i_dir) ? '0 : i_duty_target;
  assign w_goal   = (r_state == CH_DRAIN) ? '0 : w_target;
  assign w_next   = PWM_BITS'(sat_step(32'(r_duty), 32'(w_goal), STEP_LIM));
  assign w_active = (r_state == CH_RUN) || (r_state == CH_DRAIN);

  // PWM comparator with solid-off and solid-on end points
  always_comb begin
    w_pwm = 1'b0;
    if (r_duty == '0) begin
      w_pwm = 1'b0;
    end else if (r_duty == DUTY_FULL) begin
      w_pwm = 1'b1;
    end else begin
      w_pwm = (i_cnt < r_duty);
    end
  end

  // Channel FSM, applied duty and registered bridge pins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= CH_IDLE;
      r_dir    <= 1'b0;
      r_duty   <= '0;
      r_en_out <= 1'b0;
      r_in_a   <= 1'b0;
      r_in_b   <= 1'b0;
    end else if (!i_enable) begin
      r_state  <= CH_IDLE;
      r_duty   <= '0;
      r_en_out <= 1'b0;
      r_in_a   <= 1'b0;
      r_in_b   <= 1'b0;
    end else begin
      r_en_out <= w_active && w_pwm;
      r_in_a   <= w_active && r_dir;
      r_in_b   <= w_active && !r_dir;
      if (i_wrap) begin
        case (r_state)
          CH_IDLE: begin
            r_dir   <= i_dir;
            r_state <= CH_RUN;
          end
          CH_RUN: begin
            if (i_dir != r_dir) begin
              r_state <= CH_DRAIN;
            end else begin
              r_duty <= w_next;
            end
          end
          CH_DRAIN: begin
            r_duty <= w_next;
            if (w_next == '0) begin
              r_state <= CH_DEAD;
            end
          end
          CH_DEAD: begin
            // Direction is re-sampled here, so a toggle-back simply re-latches it
            r_dir   <= i_dir;
            r_state <= CH_RUN;
          end
          default: r_state <= CH_IDLE;
        endcase
      end
    end
  end

  assign o_en_out   = r_en_out;
  assign o_in_a     = r_in_a;
  assign o_in_b     = r_in_b;
  assign o_duty_now = r_duty;

endmodule

// File: rtl/multi_motor_drive.sv
// N-channel H-bridge motor driver: shared prescaler/PWM counter, obstacle
// interlock with hysteresis, and one pwm_channel per motor.
// Optional build macro: MOTOR_RAMP_EN (ramped duty changes in each channel).
module multi_motor_drive
  import motor_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 100,
  parameter int RAMP_STEP = 4,
  parameter int DIST_BITS = 33,
  parameter int STOP_DIST = 20,
  parameter int HYST      = 5
) (
  input  logic                       MAX10_CLK1_50,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CH*PWM_BITS-1:0] duty_target,
  input  logic [NUM_CH-1:0]          dir,
  input  logic [DIST_BITS-1:0]       distance,
  input  logic                       distance_valid,
  output logic [NUM_CH-1:0]          en_out,
  output logic [NUM_CH-1:0]          in_a,
  output logic [NUM_CH-1:0]          in_b,
  output logic [NUM_CH*PWM_BITS-1:0] duty_now,
  output logic                       obstacle,
  output logic                       period_start
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]      PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0]  CNT_MAX = '1;
  localparam logic [DIST_BITS-1:0] SET_LIM = DIST_BITS'(STOP_DIST);
  localparam logic [DIST_BITS-1:0] CLR_LIM = DIST_BITS'(STOP_DIST + HYST);

  logic [PS_W-1:0]     r_presc;
  logic [PWM_BITS-1:0] r_cnt;
  logic                r_period_start;
  logic                r_obstacle;
  logic                w_tick;
  logic                w_wrap;

  assign w_tick = (r_presc == PS_LAST);
  // Last clock of the period: channels commit duty/direction on this edge
  assign w_wrap = w_tick && (r_cnt == CNT_MAX);

  // Prescaler, PWM counter and the wrap pulse
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_period_start <= w_wrap;
    end
  end

  // Obstacle interlock with hysteresis band [STOP_DIST, STOP_DIST+HYST)
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_obstacle <= 1'b0;
    end else if (distance_valid) begin
      if (distance < SET_LIM) begin
        r_obstacle <= 1'b1;
      end else if (distance >= CLR_LIM) begin
        r_obstacle <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .i_clk        (MAX10_CLK1_50),
      .i_rst        (reset),
      .i_enable     (enable),
      .i_wrap       (w_wrap),
      .i_cnt        (r_cnt),
      .i_obstacle   (r_obstacle),
      .i_dir        (dir[g]),
      .i_duty_target(duty_target[g*PWM_BITS +: PWM_BITS]),
      .o_en_out     (en_out[g]),
      .o_in_a       (in_a[g]),
      .o_in_b       (in_b[g]),
      .o_duty_now   (duty_now[g*PWM_BITS +: PWM_BITS])
    );
  end

  assign obstacle     = r_obstacle;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_multi_motor_drive.sv
// Self-checking bench for multi_motor_drive (PRESCALE=2, PWM_BITS=8, 2 channels).
// Build with MOTOR_RAMP_EN defined to exercise the ramped-duty scenario instead.
module tb_multi_motor_drive;

  localparam int NUM_CH     = 2;
  localparam int PWM_BITS   = 8;
  localparam int PRESCALE   = 2;
  localparam int RAMP_STEP  = 4;
  localparam int DIST_BITS  = 33;
  localparam int STOP_DIST  = 20;
  localparam int HYST       = 5;
  localparam int PERIOD_CYC = PRESCALE * 256;
  localparam int FULL       = (1 << PWM_BITS) - 1;

  logic                       clk;
  logic                       reset;
  logic                       enable;
  logic [NUM_CH*PWM_BITS-1:0] duty_target;
  logic [NUM_CH-1:0]          dir;
  logic [DIST_BITS-1:0]       distance;
  logic                       distance_valid;
  logic [NUM_CH-1:0]          en_out;
  logic [NUM_CH-1:0]          in_a;
  logic [NUM_CH-1:0]          in_b;
  logic [NUM_CH*PWM_BITS-1:0] duty_now;
  logic                       obstacle;
  logic                       period_start;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;

  multi_motor_drive #(
    .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE), .RAMP_STEP(RAMP_STEP),
    .DIST_BITS(DIST_BITS), .STOP_DIST(STOP_DIST), .HYST(HYST)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .enable        (enable),
    .duty_target   (duty_target),
    .dir           (dir),
    .distance      (distance),
    .distance_valid(distance_valid),
    .en_out        (en_out),
    .in_a          (in_a),
    .in_b          (in_b),
    .duty_now      (duty_now),
    .obstacle      (obstacle),
    .period_start  (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Time is a cycle index inside the PWM period; each channel is described by
  // whether the bridge is engaged, which way it drives, whether a reversal is
  // winding the duty down, and whether the blank gap period is running.
  int m_cyc;
  bit m_obst;
  int m_duty   [NUM_CH];
  bit m_eng    [NUM_CH];
  bit m_fwd    [NUM_CH];
  bit m_unwind [NUM_CH];
  bit m_gap    [NUM_CH];
  bit e_en     [NUM_CH];
  bit e_a      [NUM_CH];
  bit e_b      [NUM_CH];
  bit e_ps;
  int mp_cnt;
  bit mp_wrap;
  int mp_tgt;
  bit mp_lvl;

  function automatic int approach(input int cur, input int tgt);
`ifdef MOTOR_RAMP_EN
    int d;
    d = tgt - cur;
    if (d > RAMP_STEP) d = RAMP_STEP;
    if (d < -RAMP_STEP) d = -RAMP_STEP;
    return cur + d;
`else
    return (cur >= 0) ? tgt : tgt;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cyc  = 0;
      m_obst = 0;
      e_ps   = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_duty[c] = 0; m_eng[c] = 0; m_fwd[c] = 0; m_unwind[c] = 0; m_gap[c] = 0;
        e_en[c] = 0; e_a[c] = 0; e_b[c] = 0;
      end
    end else begin
      mp_cnt  = (m_cyc / PRESCALE) % 256;
      mp_wrap = (m_cyc == PERIOD_CYC - 1);
      m_cyc   = mp_wrap ? 0 : m_cyc + 1;
      e_ps    = mp_wrap;
      for (int c = 0; c < NUM_CH; c++) begin
        mp_tgt = (m_obst && dir[c]) ? 0 : int'(duty_target[c*PWM_BITS +: PWM_BITS]);
        mp_lvl = (m_duty[c] == 0) ? 1'b0 : (m_duty[c] == FULL) ? 1'b1 : (mp_cnt < m_duty[c]);
        e_en[c] = enable && m_eng[c] && mp_lvl;
        e_a[c]  = enable && m_eng[c] && m_fwd[c];
        e_b[c]  = enable && m_eng[c] && !m_fwd[c];
        if (!enable) begin
          m_duty[c] = 0; m_eng[c] = 0; m_unwind[c] = 0; m_gap[c] = 0;
        end else if (mp_wrap) begin
          if (m_gap[c]) begin
            m_gap[c] = 0; m_eng[c] = 1; m_fwd[c] = dir[c];
          end else if (!m_eng[c]) begin
            m_eng[c] = 1; m_fwd[c] = dir[c];
          end else if (m_unwind[c]) begin
            m_duty[c] = approach(m_duty[c], 0);
            if (m_duty[c] == 0) begin
              m_unwind[c] = 0; m_eng[c] = 0; m_gap[c] = 1;
            end
          end else if (dir[c] != m_fwd[c]) begin
            m_unwind[c] = 1;
          end else begin
            m_duty[c] = approach(m_duty[c], mp_tgt);
          end
        end
      end
      if (distance_valid) begin
        if (distance < 33'(STOP_DIST)) m_obst = 1;
        else if (distance >= 33'(STOP_DIST + HYST)) m_obst = 0;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic [NUM_CH-1:0]          xe, xa, xb;
  logic [NUM_CH*PWM_BITS-1:0] xd;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < NUM_CH; c++) begin
        xe[c] = e_en[c];
        xa[c] = e_a[c];
        xb[c] = e_b[c];
        xd[c*PWM_BITS +: PWM_BITS] = PWM_BITS'(m_duty[c]);
      end
      n_cmp++;
      if ({en_out, in_a, in_b, duty_now, obstacle, period_start} !==
          {xe, xa, xb, xd, m_obst, e_ps}) begin
        n_err++;
        $display("FAIL model_cmp t=%0t got en=%b a=%b b=%b duty=%h obs=%b ps=%b / exp en=%b a=%b b=%b duty=%h obs=%b ps=%b",
                 $time, en_out, in_a, in_b, duty_now, obstacle, period_start,
                 xe, xa, xb, xd, m_obst, e_ps);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge where period_start is high, bounded by one period plus slack
  task automatic wait_ps(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < PERIOD_CYC + 8 && !seen; i++) begin
      @(negedge clk);
      if (period_start) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s period_start got=absent exp=pulse", tag);
    end
  endtask

  // Observe one full period starting from a period_start negedge
  task automatic measure(output int c0, output int c1, output int act0, output int ps_at);
    c0 = 0; c1 = 0; act0 = 0; ps_at = 0;
    for (int i = 1; i <= PERIOD_CYC; i++) begin
      @(negedge clk);
      c0   += int'(en_out[0]);
      c1   += int'(en_out[1]);
      act0 += int'(en_out[0] | in_a[0] | in_b[0]);
      if (period_start && ps_at == 0) ps_at = i;
    end
  endtask

  task automatic send_dist(input logic [DIST_BITS-1:0] v, input bit exp_obs, input string name);
    distance       = v;
    distance_valid = 1'b1;
    tick(1);
    distance_valid = 1'b0;
    check(name, obstacle, exp_obs);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    tick(3);
    check("reset_state", {en_out, in_a, in_b, duty_now, obstacle, period_start}, 64'd0);
  endtask

  int c0, c1, act0, ps_at;

  initial begin
    reset = 1'b1; enable = 1'b0; duty_target = '0; dir = '0;
    distance = '0; distance_valid = 1'b0;
    tick(2);
    chk_on = 1;
    do_reset();

`ifdef MOTOR_RAMP_EN
    // Ramp 0 -> 100 on channel 0 in steps of 4 per period
    reset = 1'b0; enable = 1'b1; dir = 2'b11; duty_target = {8'd0, 8'd100};
    wait_ps("ramp_start");
    for (int k = 1; k <= 27; k++) begin
      wait_ps("ramp_step");
      check("ramp_duty0", duty_now[7:0], (4 * k < 100) ? 4 * k : 100);
    end
    check("ramp_duty1", duty_now[15:8], 0);
`else
    // 1: 50% forward on ch0, 25% reverse on ch1
    reset = 1'b0; enable = 1'b1; dir = 2'b01; duty_target = {8'd64, 8'd128};
    wait_ps("t1_run");
    wait_ps("t1_duty");
    measure(c0, c1, act0, ps_at);
    check("t1_en0_high_cycles", c0, 256);
    check("t1_en1_high_cycles", c1, 128);
    check("t1_period_cycles", ps_at, 512);
    check("t1_pins", {in_a, in_b}, 4'b0110);
    check("t1_duty_now", duty_now, 16'h4080);

    // 2: solid off / solid on across the wrap
    duty_target = {8'd255, 8'd0};
    wait_ps("t2_apply");
    measure(c0, c1, act0, ps_at);
    check("t2_en0_high_cycles", c0, 0);
    check("t2_en1_high_cycles", c1, 512);
    check("t2_period_cycles", ps_at, 512);

    // 4: reversal of ch0 running at 200
    duty_target = {8'd255, 8'd200};
    wait_ps("t4_apply");
    check("t4_duty_200", duty_now[7:0], 200);
    tick(100);
    dir = 2'b00;
    wait_ps("t4_drain");
    check("t4_drain_duty", duty_now[7:0], 200);
    tick(10);
    check("t4_drain_in_a", in_a[0], 1);
    wait_ps("t4_dead");
    check("t4_dead_duty", duty_now[7:0], 0);
    measure(c0, c1, act0, ps_at);
    check("t4_dead_activity", act0, 0);
    check("t4_dead_period", ps_at, 512);
    tick(4);
    check("t4_rev_pins", {in_a[0], in_b[0]}, 2'b01);
    check("t4_rev_duty0", duty_now[7:0], 0);
    wait_ps("t4_rampup");
    check("t4_rev_duty200", duty_now[7:0], 200);
    check("t4_ch1_duty", duty_now[15:8], 255);

    // 5: obstacle interlock and hysteresis
    do_reset();
    reset = 1'b0; enable = 1'b1; dir = 2'b01; duty_target = {8'd100, 8'd100};
    wait_ps("t5_run");
    wait_ps("t5_duty");
    check("t5_duty", duty_now, 16'h6464);
    send_dist(33'd25, 1'b0, "t5_d25_clear");
    send_dist(33'd20, 1'b0, "t5_d20_hold0");
    send_dist(33'd19, 1'b1, "t5_d19_set");
    send_dist(33'd24, 1'b1, "t5_d24_hold1");
    send_dist(33'd25, 1'b0, "t5_d25_release");
    send_dist(33'd15, 1'b1, "t5_d15_set");
    wait_ps("t5_block");
    check("t5_fwd_blocked_rev_kept", duty_now, 16'h6400);
    check("t5_fwd_still_run", in_a[0], 1);
    send_dist(33'd22, 1'b1, "t5_d22_hold");
    send_dist(33'h1_0000_0000, 1'b0, "t5_d2p32_clear");
    wait_ps("t5_unblock");
    check("t5_unblocked", duty_now, 16'h6464);

    // 6: enable drop and reset mid-pulse
    tick(20);
    check("t6_pulse_on", en_out, 2'b11);
    enable = 1'b0;
    tick(1);
    check("t6_disable", {en_out, in_a, in_b, duty_now}, 64'd0);
    enable = 1'b1;
    wait_ps("t6_rerun");
    wait_ps("t6_reduty");
    tick(20);
    check("t6_pulse_on2", en_out, 2'b11);
    reset = 1'b1;
    tick(1);
    check("t6_reset", {en_out, in_a, in_b, duty_now, obstacle, period_start}, 64'd0);
    tick(1);
    reset = 1'b0;
    tick(5);
    check("t6_no_partial", en_out, 2'b00);
    wait_ps("t6_after_reset");
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
